// File: rtl/dm_arb.sv
// Data-memory arbiter: CPU MEM stage has default priority, external req/gnt port
// gets a forced grant after STARVE_MAX denied cycles. Optional perf counters: DM_ARB_PERF_EN.
module dm_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [6:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [6:0]  ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic [6:0]  dm_addr,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_ext_cnt
);

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 32;
    localparam logic [CW-1:0] WAIT_SAT  = '1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(STARVE_MAX - 1);

    logic          force_q, force_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          ext_rvalid_q, ext_rvalid_d;
    logic [DW-1:0] ext_rdata_q, ext_rdata_d;
    logic          cpu_act_c;
    logic          ext_own_c;

    // Owner selection and dm drive
    always_comb begin
        cpu_act_c = cpu_rd | cpu_wr;
        ext_own_c = ext_req & (force_q | ~cpu_act_c);

        ext_gnt   = ext_own_c;
        cpu_stall = ext_own_c & cpu_act_c;
        cpu_rdata = dm_rdata;
        dm_addr   = cpu_addr;
        dm_wdata  = cpu_wdata;
        dm_rd     = 1'b0;
        dm_wr     = 1'b0;

        if (ext_own_c) begin
            dm_addr  = ext_addr;
            dm_wdata = ext_wdata;
            dm_rd    = ~ext_we;
            dm_wr    = ext_we;
        end else if (cpu_act_c) begin
            dm_rd = cpu_rd;
            dm_wr = cpu_wr;
        end
    end

    // Starvation tracking and external read capture
    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        force_d      = force_q;
        ext_rvalid_d = 1'b0;
        ext_rdata_d  = ext_rdata_q;

        if (!ext_req || ext_own_c) begin
            wait_cnt_d = '0;
            force_d    = 1'b0;
        end else begin
            if (wait_cnt_q != WAIT_SAT) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
            if (wait_cnt_q == WAIT_LAST) begin
                force_d = 1'b1;
            end
        end

        if (ext_own_c && !ext_we) begin
            ext_rvalid_d = 1'b1;
            ext_rdata_d  = dm_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q   <= '0;
            force_q      <= 1'b0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            force_q      <= force_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

`ifdef DM_ARB_PERF_EN
    localparam int unsigned PW = 16;
    localparam logic [PW-1:0] PERF_SAT = '1;

    logic [PW-1:0] perf_stall_q, perf_stall_d;
    logic [PW-1:0] perf_ext_q, perf_ext_d;

    // Saturating event counters
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_ext_d   = perf_ext_q;
        if (cpu_stall && perf_stall_q != PERF_SAT) begin
            perf_stall_d = perf_stall_q + PW'(1);
        end
        if (ext_gnt && perf_ext_q != PERF_SAT) begin
            perf_ext_d = perf_ext_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_ext_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_ext_q   <= perf_ext_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_ext_cnt   = perf_ext_q;
`else
    assign perf_stall_cnt = 16'h0000;
    assign perf_ext_cnt   = 16'h0000;
`endif

endmodule

// File: doc/dm_arb.md
Name: dm_arb

Overview:
- Arbiter sharing the single-port 128x32 data memory (dm) between two requesters.
  - The CPU MEM stage has default priority.
  - An external requester (DMA or debug loader) uses a req/gnt handshake.
- Starvation protection: after STARVE_MAX denied cycles, the external port is forced through for one access and the CPU is stalled.
- Sits between the pipeline MEM stage and dm; drives all dm inputs.

Parameters:
- STARVE_MAX, 4, number of consecutive denied ext_req cycles before a forced ext grant. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- cpu_rd  in  1  CPU load request
- cpu_wr  in  1  CPU store request
- cpu_addr  in  7  CPU word address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  CPU load data (combinational from dm)
- cpu_stall  out  1  CPU access not performed this cycle; CPU holds its inputs
- ext_req  in  1  external access request
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  7  external word address
- ext_wdata  in  32  external write data
- ext_gnt  out  1  external access performed this cycle
- ext_rvalid  out  1  one-cycle pulse: ext_rdata valid
- ext_rdata  out  32  registered external read data
- dm_addr  out  7  to dm addr
- dm_rd  out  1  to dm rd
- dm_wr  out  1  to dm wr
- dm_wdata  out  32  to dm wdata
- dm_rdata  in  32  from dm rdata
- perf_stall_cnt  out  16  forced-stall counter (see Optional Feature)
- perf_ext_cnt  out  16  ext grant counter (see Optional Feature)

Behaviour:
- Definitions:
  - cpu_act = cpu_rd | cpu_wr.
  - force = internal register.
  - wait_cnt = internal 8-bit counter.
- Owner selection (combinational, every cycle):
  - force=0: cpu_act → CPU owns; else ext_req → ext owns; else none.
  - force=1: ext_req → ext owns, cpu_stall = cpu_act; else CPU owns if cpu_act.
- CPU owns:
  - dm_addr=cpu_addr, dm_rd=cpu_rd, dm_wr=cpu_wr, dm_wdata=cpu_wdata.
  - ext_gnt=0, cpu_stall=0.
- ext owns:
  - dm_addr=ext_addr, dm_rd=~ext_we, dm_wr=ext_we, dm_wdata=ext_wdata, ext_gnt=1.
- None:
  - dm_rd=dm_wr=0, dm_addr=cpu_addr, dm_wdata=cpu_wdata.
- cpu_rdata = dm_rdata at all times; the CPU ignores it while cpu_stall=1.
- ext handshake:
  - ext holds req/we/addr/wdata stable from assertion until the cycle ext_gnt=1.
  - The access completes in that cycle.
  - ext may deassert, or present a new request, the following cycle.
- ext read:
  - At the grant edge, ext_rdata <= dm_rdata.
  - ext_rvalid=1 for exactly the next cycle.
  - ext_rdata holds until the next ext read.
  - An ext write never pulses ext_rvalid.
- wait_cnt:
  - Increments on each edge where ext_req=1 and ext_gnt=0; saturates at 255.
  - Cleared on ext_gnt=1 or ext_req=0.
- force:
  - Set at the edge where ext_req=1, ext_gnt=0, and wait_cnt==STARVE_MAX-1.
  - Cleared at the edge where ext_gnt=1 or ext_req=0.
  - So the grant lands in the (STARVE_MAX+1)th request cycle.
- cpu_stall lasts exactly one cycle per forced grant. Back-to-back ext requests restart counting from 0.
- Simultaneous CPU read and ext write to the same address cannot occur: only one owner per cycle.
- Reset (rst_n=0 at a clk edge, including mid-wait or mid-forced-cycle): wait_cnt=0, force=0, ext_rvalid=0, ext_rdata=0, perf counters=0.
  - Combinational outputs follow owner selection with force=0.
  - In the cycle after reset, cpu_stall=0.

Optional Feature:
- Macro DM_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle cpu_stall=1.
  - perf_ext_cnt increments each cycle ext_gnt=1.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- Not defined: both ports are tied to 16'h0000 and no counter registers exist.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all inputs 0 → ext_gnt=0, ext_rvalid=0, ext_rdata=0, cpu_stall=0, dm_rd=dm_wr=0.
- No contention: CPU writes 0xDEADBEEF to 0x10. Next cycle, with CPU idle, ext reads 0x10 → ext_gnt=1 that cycle; next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF.
- Starvation (STARVE_MAX=4): cpu_rd=1 continuously; ext_req write 0x00001234 to 0x05 from cycle 0 → ext_gnt=0 in cycles 0-3; in cycle 4 ext_gnt=1, cpu_stall=1, dm_wr=1, dm_addr=0x05. In cycle 5 cpu_stall=0; a subsequent CPU read of 0x05 returns 0x00001234.
- Request withdrawal: under continuous CPU traffic, ext_req high for 3 cycles, low for 1, then high again → no grant until 4 more denied cycles have elapsed (grant in the 5th cycle after re-assertion).
- Reset mid-force: in the STARVE_MAX=4 scenario, rst_n=0 at the edge ending cycle 3 → cycle 4 has cpu_stall=0, ext_gnt=0; force is regained only after 4 further denied cycles.
- Perf (DM_ARB_PERF_EN defined): run the starvation scenario twice → perf_stall_cnt=2, perf_ext_cnt=2. Without the macro, both read 0.
